// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for the five-stage MIPS datapath. It produces the
// PC enable and the four pipeline-latch enable/flush controls. It handles:
//   - load-use interlock (one bubble),
//   - branch/jump redirect (squash IF/ID and ID/EX),
//   - data-memory wait (whole-pipeline freeze until dhit),
//   - halt (sticky freeze, left only through reset).
//
// Ports
//   CLK, RST                 clock; synchronous active-high reset
//   ihit, dhit               fetch / data access complete this cycle
//   ifid_rs, ifid_rt         source registers of the instruction in IF/ID
//   idex_dREN_out            instruction in EX is a load
//   idex_reg_rt_out          load destination register in EX
//   ex_redirect              EX resolved a taken branch or a jump
//   exmem_dREN, exmem_dWEN   memory-stage access request
//   exmem_halt               halt instruction in MEM
//   pc_en, *_en              PC and latch enables
//   ifid_flush, idex_flush   load a bubble on the next edge
//   halted                   sticky halt indication
//   hz_state                 0 RUN, 1 MEM_WAIT, 2 HALTED
//
// Optional feature (macro HAZARD_PERF_EN):
//   stall_cycles  32-bit count of RUN/MEM_WAIT cycles with pc_en low
//   flush_count   32-bit count of cycles with idex_flush high outside reset
// ----------------------------------------------------------------------------
module hazard_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       idex_dREN_out,
    input  logic [4:0] idex_reg_rt_out,
    input  logic       ex_redirect,
    input  logic       exmem_dREN,
    input  logic       exmem_dWEN,
    input  logic       exmem_halt,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       halted,
    output logic [1:0] hz_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } hz_state_e;

    // Control vector order: {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    //                        ifid_flush, idex_flush}
    localparam logic [6:0] CTRL_FREEZE = 7'b0000000;
    localparam logic [6:0] CTRL_RESET  = 7'b0000011;
    localparam logic [6:0] CTRL_RUN    = 7'b1111100;
    localparam logic [6:0] CTRL_REDIR  = 7'b1111111;
    localparam logic [6:0] CTRL_LDUSE  = 7'b0011101;
    localparam logic [6:0] CTRL_NOFET  = 7'b0111110;

    hz_state_e  state_q;
    hz_state_e  state_d;
    logic [6:0] ctrl_s;
    logic       halted_s;
    logic       memop_s;
    logic       loaduse_s;

    // Controls when every latch may advance. The redirect beats load-use
    // because the dependent consumer is squashed anyway, and it beats !ihit
    // because pc_en must load the branch target.
    function automatic logic [6:0] advance_ctrl(input logic redirect,
                                                input logic lu,
                                                input logic ih);
        logic [6:0] c;
        if (redirect) begin
            c = CTRL_REDIR;
        end else if (lu) begin
            c = CTRL_LDUSE;
        end else if (!ih) begin
            c = CTRL_NOFET;
        end else begin
            c = CTRL_RUN;
        end
        return c;
    endfunction

    // Hazard detection terms; register 0 is never a real dependency.
    always_comb begin
        memop_s   = exmem_dREN | exmem_dWEN;
        loaduse_s = idex_dREN_out & (idex_reg_rt_out != 5'd0) &
                    ((idex_reg_rt_out == ifid_rs) | (idex_reg_rt_out == ifid_rt));
    end

    // Next-state and control outputs.
    always_comb begin
        state_d  = state_q;
        ctrl_s   = CTRL_FREEZE;
        halted_s = 1'b0;
        if (RST) begin
            state_d = ST_RUN;
            ctrl_s  = CTRL_RESET;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (exmem_halt) begin
                        state_d = ST_HALTED;
                    end else if (memop_s && !dhit) begin
                        state_d = ST_MEM_WAIT;
                    end else begin
                        ctrl_s = advance_ctrl(ex_redirect, loaduse_s, ihit);
                    end
                end
                ST_MEM_WAIT: begin
                    // EX is held during the wait, so a pending redirect or
                    // load-use is simply re-evaluated in the dhit cycle.
                    if (dhit) begin
                        state_d = ST_RUN;
                        ctrl_s  = advance_ctrl(ex_redirect, loaduse_s, ihit);
                    end else begin
                        state_d = ST_MEM_WAIT;
                    end
                end
                ST_HALTED: begin
                    state_d  = ST_HALTED;
                    halted_s = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_flush, idex_flush} = ctrl_s;
    assign halted   = halted_s;
    assign hz_state = state_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;
    logic [31:0] flush_count_q;
    logic [31:0] flush_count_d;

    // Counter next values; both hold in HALTED and wrap naturally.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (RST) begin
            stall_cycles_d = 32'd0;
            flush_count_d  = 32'd0;
        end else if (state_q != ST_HALTED) begin
            if (!ctrl_s[6]) begin
                stall_cycles_d = stall_cycles_q + 32'd1;
            end else begin
                stall_cycles_d = stall_cycles_q;
            end
            if (ctrl_s[0]) begin
                flush_count_d = flush_count_q + 32'd1;
            end else begin
                flush_count_d = flush_count_q;
            end
        end else begin
            stall_cycles_d = stall_cycles_q;
            flush_count_d  = flush_count_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge CLK) begin
        stall_cycles_q <= stall_cycles_d;
        flush_count_q  <= flush_count_d;
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl: table-driven self-checking bench for hazard_ctrl.
// Each row is one clock cycle of inputs plus the expected controls, halted
// and state for that cycle. Expected entries go into a scoreboard queue when
// the row is driven and are popped and compared on the falling edge.
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic       CLK;
    logic       RST;
    logic       ihit;
    logic       dhit;
    logic [4:0] ifid_rs;
    logic [4:0] ifid_rt;
    logic       idex_dREN_out;
    logic [4:0] idex_reg_rt_out;
    logic       ex_redirect;
    logic       exmem_dREN;
    logic       exmem_dWEN;
    logic       exmem_halt;
    logic       pc_en;
    logic       ifid_en;
    logic       idex_en;
    logic       exmem_en;
    logic       memwb_en;
    logic       ifid_flush;
    logic       idex_flush;
    logic       halted;
    logic [1:0] hz_state;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
    logic [31:0] exp_stall;
    logic [31:0] exp_flush;
`endif

    hazard_ctrl dut (
        .CLK             (CLK),
        .RST             (RST),
        .ihit            (ihit),
        .dhit            (dhit),
        .ifid_rs         (ifid_rs),
        .ifid_rt         (ifid_rt),
        .idex_dREN_out   (idex_dREN_out),
        .idex_reg_rt_out (idex_reg_rt_out),
        .ex_redirect     (ex_redirect),
        .exmem_dREN      (exmem_dREN),
        .exmem_dWEN      (exmem_dWEN),
        .exmem_halt      (exmem_halt),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .halted          (halted),
        .hz_state        (hz_state)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}
    localparam logic [6:0] C_RST = 7'b0000011;
    localparam logic [6:0] C_RUN = 7'b1111100;
    localparam logic [6:0] C_FRZ = 7'b0000000;
    localparam logic [6:0] C_LU  = 7'b0011101;
    localparam logic [6:0] C_NOI = 7'b0111110;
    localparam logic [6:0] C_RED = 7'b1111111;

    typedef struct {
        logic       rst;
        logic       ih;
        logic       dh;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ld;
        logic [4:0] ld_rt;
        logic       redir;
        logic       dren;
        logic       dwen;
        logic       halt;
        logic [6:0] ctrl;
        logic       hlt;
        logic [1:0] st;
    } vec_t;

    typedef struct {
        int         idx;
        logic       rst;
        logic [6:0] ctrl;
        logic       hlt;
        logic [1:0] st;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic rst, input logic ih, input logic dh,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic ld, input logic [4:0] ld_rt,
                                input logic redir, input logic dren,
                                input logic dwen, input logic halt,
                                input logic [6:0] ctrl, input logic hlt,
                                input logic [1:0] st);
        vec_t v;
        v.rst = rst; v.ih = ih; v.dh = dh; v.rs = rs; v.rt = rt;
        v.ld = ld; v.ld_rt = ld_rt; v.redir = redir; v.dren = dren;
        v.dwen = dwen; v.halt = halt; v.ctrl = ctrl; v.hlt = hlt; v.st = st;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        RST             = v.rst;
        ihit            = v.ih;
        dhit            = v.dh;
        ifid_rs         = v.rs;
        ifid_rt         = v.rt;
        idex_dREN_out   = v.ld;
        idex_reg_rt_out = v.ld_rt;
        ex_redirect     = v.redir;
        exmem_dREN      = v.dren;
        exmem_dWEN      = v.dwen;
        exmem_halt      = v.halt;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t       e;
        exp_t       got;
        logic [6:0] act;
        drive(v);
        e.idx = idx; e.rst = v.rst; e.ctrl = v.ctrl; e.hlt = v.hlt; e.st = v.st;
        exp_q.push_back(e);
        @(negedge CLK);
        got = exp_q.pop_front();
        act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
        total++;
        if (act !== got.ctrl) begin
            bad++;
            $display("FAIL ctrl row %0d: got %b want %b", got.idx, act, got.ctrl);
        end
        total++;
        if (halted !== got.hlt) begin
            bad++;
            $display("FAIL halted row %0d: got %b want %b", got.idx, halted, got.hlt);
        end
        total++;
        if (hz_state !== got.st) begin
            bad++;
            $display("FAIL state row %0d: got %0d want %0d", got.idx, hz_state, got.st);
        end
`ifdef HAZARD_PERF_EN
        if (got.rst) begin
            exp_stall = 32'd0;
            exp_flush = 32'd0;
        end else if (got.st != 2'd2) begin
            if (!got.ctrl[6]) exp_stall = exp_stall + 32'd1;
            if (got.ctrl[0])  exp_flush = exp_flush + 32'd1;
        end
`endif
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vec_t idle;
        idle = mk(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                  C_RST, 1'b0, 2'd0);
        drive(idle);
`ifdef HAZARD_PERF_EN
        exp_stall = 32'd0;
        exp_flush = 32'd0;
`endif
        // reset for two cycles, then normal running
        tbl.push_back(idle);
        tbl.push_back(idle);
        tbl.push_back(mk(0,1,0, 0,0, 0,0, 0,0,0,0, C_RUN,0,0));
        // load-use via rs, then clears as the load moves on
        tbl.push_back(mk(0,1,0, 8,0, 1,8, 0,0,0,0, C_LU ,0,0));
        tbl.push_back(mk(0,1,0, 8,0, 0,8, 0,0,0,0, C_RUN,0,0));
        // destination register 0 never interlocks
        tbl.push_back(mk(0,1,0, 0,0, 1,0, 0,0,0,0, C_RUN,0,0));
        // load-use via rt; non-matching registers
        tbl.push_back(mk(0,1,0, 3,5, 1,5, 0,0,0,0, C_LU ,0,0));
        tbl.push_back(mk(0,1,0, 6,7, 1,5, 0,0,0,0, C_RUN,0,0));
        // fetch miss
        tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0,0, C_NOI,0,0));
        // redirect beats load-use and fetch miss
        tbl.push_back(mk(0,0,0, 8,0, 1,8, 1,0,0,0, C_RED,0,0));
        // load miss: three freeze cycles, advance on dhit
        tbl.push_back(mk(0,1,0, 0,0, 0,0, 0,1,0,0, C_FRZ,0,0));
        tbl.push_back(mk(0,1,0, 0,0, 0,0, 0,1,0,0, C_FRZ,0,1));
        tbl.push_back(mk(0,1,0, 0,0, 0,0, 0,1,0,0, C_FRZ,0,1));
        tbl.push_back(mk(0,1,1, 0,0, 0,0, 0,1,0,0, C_RUN,0,1));
        tbl.push_back(mk(0,1,0, 0,0, 0,0, 0,0,0,0, C_RUN,0,0));
        // store miss with redirect: freeze wins, redirect applied on dhit
        tbl.push_back(mk(0,1,0, 0,0, 0,0, 1,0,1,0, C_FRZ,0,0));
        tbl.push_back(mk(0,1,1, 0,0, 0,0, 1,0,1,0, C_RED,0,1));
        tbl.push_back(mk(0,1,0, 0,0, 0,0, 0,0,0,0, C_RUN,0,0));
        // miss resolving with a pending load-use
        tbl.push_back(mk(0,1,0, 0,0, 0,0, 0,1,0,0, C_FRZ,0,0));
        tbl.push_back(mk(0,1,1, 8,0, 1,8, 0,1,0,0, C_LU ,0,1));
        tbl.push_back(mk(0,1,0, 0,0, 0,0, 0,0,0,0, C_RUN,0,0));
        // memop that hits immediately does not stall
        tbl.push_back(mk(0,1,1, 0,0, 0,0, 0,1,0,0, C_RUN,0,0));
        // miss resolving together with a fetch miss
        tbl.push_back(mk(0,1,0, 0,0, 0,0, 0,0,1,0, C_FRZ,0,0));
        tbl.push_back(mk(0,0,1, 0,0, 0,0, 0,0,1,0, C_NOI,0,1));
        tbl.push_back(mk(0,1,0, 0,0, 0,0, 0,0,0,0, C_RUN,0,0));
        // reset in the middle of a memory wait
        tbl.push_back(mk(0,1,0, 0,0, 0,0, 0,1,0,0, C_FRZ,0,0));
        tbl.push_back(mk(0,1,0, 0,0, 0,0, 0,1,0,0, C_FRZ,0,1));
        tbl.push_back(mk(1,1,0, 0,0, 0,0, 0,1,0,0, C_RST,0,1));
        tbl.push_back(mk(0,1,0, 0,0, 0,0, 0,0,0,0, C_RUN,0,0));
        // halt: sticky for 10 cycles, cleared only by reset
        tbl.push_back(mk(0,1,0, 0,0, 0,0, 0,0,0,1, C_FRZ,0,0));
        for (int i = 0; i < 10; i++) begin
            tbl.push_back(mk(0,1,1, 8,0, 1,8, 1,0,0,0, C_FRZ,1,2));
        end
        tbl.push_back(mk(1,1,0, 0,0, 0,0, 0,0,0,0, C_RST,0,2));
        tbl.push_back(mk(0,1,0, 0,0, 0,0, 0,0,0,0, C_RUN,0,0));

        @(posedge CLK);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], i);
        end

`ifdef HAZARD_PERF_EN
        // counters against the bench's running model
        @(negedge CLK);
        total++;
        if (stall_cycles !== exp_stall) begin
            bad++;
            $display("FAIL stall_cycles: got %0d want %0d", stall_cycles, exp_stall);
        end
        total++;
        if (flush_count !== exp_flush) begin
            bad++;
            $display("FAIL flush_count: got %0d want %0d", flush_count, exp_flush);
        end
        // stall counter wraps from all-ones to zero after one stall cycle
        drive(mk(0,0,0, 0,0, 0,0, 0,0,0,0, C_NOI,0,0));
        force dut.stall_cycles_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cycles_q;
        @(posedge CLK);
        @(negedge CLK);
        total++;
        if (stall_cycles !== 32'd0) begin
            bad++;
            $display("FAIL stall_wrap: got %0d want 0", stall_cycles);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
